// File: rtl/serial_addsub_ctrl_if.sv
// serial_addsub_ctrl_if: start/busy/done bundle
// carrying operands, op select and result.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cb_out;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cb_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cb_out
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/sub using
// one full-adder/subtractor cell, LSB first.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_addsub_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] sa, sb, acc;
  logic [CW-1:0]    cnt;
  logic             sop;
  logic             c;

  logic load, step, last;
  logic ai, bi, s, c_next;

  assign ai   = sa[0];
  assign bi   = sb[0];
  assign s    = ai ^ bi ^ c;
  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    if (sop)
      c_next = (~ai & bi) | (c & ~(ai ^ bi));
    else
      c_next = (ai & bi) | (c & (ai ^ bi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last)
          state_n = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      acc        <= '0;
      cnt        <= '0;
      sop        <= 1'b0;
      c          <= 1'b0;
      bus.result <= '0;
      bus.cb_out <= 1'b0;
    end else if (load) begin
      sa  <= bus.a;
      sb  <= bus.b;
      sop <= bus.op;
      acc <= '0;
      cnt <= '0;
      c   <= 1'b0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= {s, acc[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      c   <= c_next;
      // partial sum stays internal; publish only when complete
      if (last) begin
        bus.result <= {s, acc[WIDTH-1:1]};
        bus.cb_out <= c_next;
      end
    end
  end
endmodule
